// File: rtl/inst_sched.sv
// Instruction scheduler: step FIFO feeding a one-shot issue FSM with SEND/UART handshake.
// Optional SEND timeout enabled by defining INST_SCHED_TX_TIMEOUT_EN.
module inst_sched #(
    parameter int FIFO_AW    = 2,
    parameter int TX_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step_vld,
    input  logic [7:0]         step_wd,
    output logic               step_rdy,
    output logic               inst_vld,
    output logic [7:0]         inst_wd,
    input  logic               uart_busy,
    output logic [FIFO_AW:0]   fifo_cnt,
    output logic               ovf,
    output logic               tx_to
);
    localparam int DEPTH = 2 ** FIFO_AW;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_TX} state_t;

    state_t               state_q, state_d;
    logic [7:0]           mem_q [DEPTH];
    logic [7:0]           mem_d [DEPTH];
    logic [FIFO_AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [FIFO_AW:0]     cnt_q, cnt_d;
    logic                 vld_q, vld_d;
    logic [7:0]           wd_q, wd_d;
    logic                 ovf_q, ovf_d;
    logic                 seen_q, seen_d;
    logic                 push, pop, head_send;
    logic [7:0]           head;

`ifdef INST_SCHED_TX_TIMEOUT_EN
    localparam int TW = $clog2(TX_TIMEOUT + 1);
    logic [TW-1:0]        tmr_q, tmr_d;
    logic                 tx_to_q, tx_to_d;
    assign tx_to = tx_to_q;
`else
    assign tx_to = 1'b0;
`endif

    assign step_rdy  = (cnt_q != (FIFO_AW + 1)'(DEPTH));
    assign push      = step_vld & step_rdy;
    assign pop       = (state_q == ISSUE);
    assign head      = mem_q[rd_q];
    assign head_send = (head[7:6] == 2'b11);
    assign inst_vld  = vld_q;
    assign inst_wd   = wd_q;
    assign fifo_cnt  = cnt_q;
    assign ovf       = ovf_q;

    always_comb begin
        state_d = state_q;
        seen_d  = seen_q;
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        wd_d    = wd_q;
        ovf_d   = ovf_q | (step_vld & ~step_rdy);
`ifdef INST_SCHED_TX_TIMEOUT_EN
        tmr_d   = tmr_q;
        tx_to_d = tx_to_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cnt_q != '0 && (!head_send || !uart_busy))
                    state_d = ISSUE;
            end
            ISSUE: begin
                state_d = head_send ? WAIT_TX : IDLE;
                seen_d  = 1'b0;
`ifdef INST_SCHED_TX_TIMEOUT_EN
                tmr_d   = '0;
`endif
            end
            WAIT_TX: begin
`ifdef INST_SCHED_TX_TIMEOUT_EN
                tmr_d = tmr_q + 1'b1;
`endif
                if (seen_q && !uart_busy)
                    state_d = IDLE;
                else if (uart_busy)
                    seen_d = 1'b1;
`ifdef INST_SCHED_TX_TIMEOUT_EN
                else if (tmr_q == TW'(TX_TIMEOUT - 1)) begin
                    state_d = IDLE;
                    tx_to_d = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        // strobe and word are registered on entry to ISSUE
        vld_d = (state_d == ISSUE);
        if (vld_d)
            wd_d = head;
        if (push) begin
            mem_d[wr_q] = step_wd;
            wr_d        = wr_q + 1'b1;
        end
        if (pop)
            rd_d = rd_q + 1'b1;
        if (push && !pop)
            cnt_d = cnt_q + 1'b1;
        else if (!push && pop)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            vld_q   <= 1'b0;
            wd_q    <= 8'h00;
            ovf_q   <= 1'b0;
            seen_q  <= 1'b0;
`ifdef INST_SCHED_TX_TIMEOUT_EN
            tmr_q   <= '0;
            tx_to_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            wd_q    <= wd_d;
            ovf_q   <= ovf_d;
            seen_q  <= seen_d;
`ifdef INST_SCHED_TX_TIMEOUT_EN
            tmr_q   <= tmr_d;
            tx_to_q <= tx_to_d;
`endif
        end
    end
endmodule

// File: tb/tb_inst_sched.sv
// Randomised and directed bench for inst_sched against a queue-based model.
module tb_inst_sched;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       step_vld = 1'b0;
    logic [7:0] step_wd = 8'h00;
    logic       uart_busy = 1'b0;
    logic       step_rdy, inst_vld, ovf, tx_to;
    logic [7:0] inst_wd;
    logic [2:0] fifo_cnt;

    inst_sched #(.FIFO_AW(2), .TX_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .step_vld(step_vld), .step_wd(step_wd),
        .step_rdy(step_rdy), .inst_vld(inst_vld), .inst_wd(inst_wd),
        .uart_busy(uart_busy), .fifo_cnt(fifo_cnt), .ovf(ovf), .tx_to(tx_to)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_acc = 0;

    logic [7:0] mq[$];
    bit         m_vld, m_ovf, m_to, m_wait, m_seen;
    logic [7:0] m_wd = 8'h00;
    int         m_tmr;
    logic [7:0] ilog[$];
    int         itag[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Model: issue the queue head two cycles after it is visible,
    // SENDs wait for an idle UART and then a busy pulse to complete.
    always @(posedge clk) begin
        bit         sv, bz, r, full, pop;
        logic [7:0] sw;
        sv = step_vld; sw = step_wd; bz = uart_busy; r = rst;
        if (r) begin
            mq.delete();
            m_vld = 0; m_wd = 8'h00; m_ovf = 0; m_to = 0;
            m_wait = 0; m_seen = 0; m_tmr = 0;
        end else begin
            full = (mq.size() == 4);
            pop = 0;
            if (m_vld) begin
                pop = 1;
                m_vld = 0;
                if (mq[0][7:6] == 2'b11) begin
                    m_wait = 1; m_seen = 0; m_tmr = 0;
                end
            end else if (m_wait) begin
                m_tmr++;
                if (m_seen && !bz) m_wait = 0;
                else if (bz) m_seen = 1;
`ifdef INST_SCHED_TX_TIMEOUT_EN
                else if (m_tmr == TO) begin
                    m_wait = 0; m_to = 1;
                end
`endif
            end else if (mq.size() > 0 && (mq[0][7:6] != 2'b11 || !bz)) begin
                m_vld = 1;
                m_wd = mq[0];
            end
            if (pop) void'(mq.pop_front());
            if (sv) begin
                if (full) m_ovf = 1;
                else begin
                    mq.push_back(sw);
                    last_acc = cyc;
                end
            end
        end
        cyc++;
        #1;
        chk("inst_vld", 32'(inst_vld), 32'(m_vld));
        chk("inst_wd", 32'(inst_wd), 32'(m_wd));
        chk("fifo_cnt", 32'(fifo_cnt), 32'(mq.size()));
        chk("step_rdy", 32'(step_rdy), 32'(mq.size() != 4));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("tx_to", 32'(tx_to), 32'(m_to));
        if (inst_vld === 1'b1) begin
            ilog.push_back(inst_wd);
            itag.push_back(cyc);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic step(input logic [7:0] w);
        step_vld = 1'b1;
        step_wd = w;
        tick();
        step_vld = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ilog.delete();
        itag.delete();
    endtask

    task automatic wait_log(input int n, input int budget, input string nm);
        int k = 0;
        while (ilog.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(nm, 32'(ilog.size() >= n), 32'd1);
    endtask

    initial begin
        int fall;
        int ent;
        int to_tag;
        logic [7:0] burst [5];
        burst = '{8'h04, 8'h00, 8'h13, 8'h86, 8'h4B};
        tick(2);
        do_reset();
        chk("rst_cnt", 32'(fifo_cnt), 32'd0);
        chk("rst_rdy", 32'(step_rdy), 32'd1);
        chk("rst_wd", 32'(inst_wd), 32'h00);
        chk("rst_vld", 32'(inst_vld), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);

        step(8'h04);
        tick(4);
        chk("lat_n", 32'(ilog.size()), 32'd1);
        chk("lat_wd", 32'(ilog.size() > 0 ? ilog[0] : 8'hxx), 32'h04);
        chk("lat_cyc", 32'(itag.size() > 0 ? itag[0] - last_acc : -1), 32'd2);
        chk("lat_cnt", 32'(fifo_cnt), 32'd0);

        do_reset();
        step(8'hC0);
        wait_log(1, 20, "ovf_send_to");
        uart_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step_vld = 1'b1;
            step_wd = burst[i];
            tick();
        end
        step_vld = 1'b0;
        tick(3);
        chk("ovf_flag", 32'(ovf), 32'd1);
        chk("ovf_cnt", 32'(fifo_cnt), 32'd4);
        chk("ovf_held", 32'(ilog.size()), 32'd1);
        uart_busy = 1'b0;
        wait_log(5, 40, "ovf_drain_to");
        for (int i = 0; i < 4; i++)
            chk("ovf_order", 32'(ilog.size() > i + 1 ? ilog[i+1] : 8'hxx),
                32'(burst[i]));
        tick(6);
        chk("ovf_drop", 32'(ilog.size()), 32'd5);

        do_reset();
        uart_busy = 1'b1;
        step(8'hC0);
        tick(6);
        chk("stall", 32'(ilog.size()), 32'd0);
        uart_busy = 1'b0;
        wait_log(1, 20, "send_to");
        chk("send_wd", 32'(ilog.size() > 0 ? ilog[0] : 8'hxx), 32'hC0);
        uart_busy = 1'b1;
        step(8'h4B);
        tick(4);
        uart_busy = 1'b0;
        fall = cyc;
        wait_log(2, 20, "after_to");
        chk("after_wd", 32'(ilog.size() > 1 ? ilog[1] : 8'hxx), 32'h4B);
        chk("after_busy", 32'(itag.size() > 1 && itag[1] > fall), 32'd1);

`ifdef INST_SCHED_TX_TIMEOUT_EN
        do_reset();
        step(8'hC0);
        step(8'h04);
        wait_log(1, 20, "tmo_send_to");
        ent = (itag.size() > 0) ? itag[0] + 1 : 0;
        begin
            int k = 0;
            while (tx_to !== 1'b1 && k < 40) begin
                tick();
                k++;
            end
        end
        to_tag = cyc;
        chk("tmo_flag", 32'(tx_to), 32'd1);
        chk("tmo_cyc", 32'(to_tag - ent), 32'd16);
        wait_log(2, 10, "tmo_next_to");
        chk("tmo_next", 32'(ilog.size() > 1 ? ilog[1] : 8'hxx), 32'h04);
        chk("tmo_next_cyc", 32'(itag.size() > 1 ? itag[1] - to_tag : -1), 32'd1);
`else
        ent = 0;
        to_tag = 0;
`endif

        do_reset();
        step(8'hC0);
        wait_log(1, 20, "mid_send_to");
        uart_busy = 1'b1;
        step(8'h11);
        step(8'h22);
        step(8'h33);
        tick(2);
        chk("mid_cnt3", 32'(fifo_cnt), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_cnt0", 32'(fifo_cnt), 32'd0);
        chk("mid_vld", 32'(inst_vld), 32'd0);
        uart_busy = 1'b0;
        tick(10);
        chk("mid_quiet", 32'(ilog.size()), 32'd1);
        step(8'h05);
        wait_log(2, 10, "mid_new_to");
        chk("mid_new", 32'(ilog.size() > 1 ? ilog[1] : 8'hxx), 32'h05);

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step_vld = ($urandom_range(0, 2) == 0);
            step_wd = 8'($urandom);
            if ($urandom_range(0, 3) == 0) uart_busy = ~uart_busy;
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0;
        step_vld = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
